// File: rtl/fp_alu_pipe.sv
// fp_alu_pipe: pipelined IEEE-754 single-precision ALU for the execute stage.
// Ops: add, sub, mul, compare, min, max, eq (reserved opcode returns 0).
// Optional feature macro: FP_ALU_EXC_EN adds the exc port {invalid, overflow, underflow}.
//
// Handshake: an op is taken on a cycle where in_valid && in_ready; a result is
// taken on a cycle where out_valid && out_ready. stall = out_valid && !out_ready
// freezes every stage at once, in_ready = !stall, and bubbles are never collapsed,
// so results leave in acceptance order after exactly LATENCY unstalled edges.
module fp_alu_pipe #(
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [2:0]       op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out,
  output logic             gt,
  output logic [TAG_W-1:0] out_tag
`ifdef FP_ALU_EXC_EN
  ,
  output logic [2:0]       exc
`endif
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

  // Significand with the hidden bit restored (0 for subnormals).
  function automatic logic [23:0] sig_of(input logic [31:0] x);
    return {(x[30:23] != 8'd0), x[22:0]};
  endfunction

  // Effective biased exponent; subnormals share the scale of exponent 1.
  function automatic int exp_of(input logic [31:0] x);
    return (x[30:23] == 8'd0) ? 1 : {24'd0, x[30:23]};
  endfunction

  // Logical right shift that folds every shifted-out bit into bit 0.
  function automatic logic [49:0] shr_sticky(input logic [49:0] x, input int sh);
    logic [49:0] mask;
    mask = (50'd1 << sh) - 50'd1;
    return (x >> sh) | {49'd0, |(x & mask)};
  endfunction

  // Normalise, round-to-nearest-even and pack. The value is m * 2^(e-127) with
  // the binary point just below bit 48. Returns {overflow, underflow, result}.
  function automatic logic [33:0] round_pack(input logic s, input int e_in,
                                             input logic [49:0] m_in);
    logic [49:0] m;
    logic [24:0] f;
    logic [31:0] r;
    logic        sub, rnd, ovf, unf;
    int          e, p;
    m = m_in;
    e = e_in;
    p = 0;
    sub = 1'b0;
    ovf = 1'b0;
    unf = 1'b0;
    if (m == 50'd0) return {2'b00, s, 31'd0};
    for (int i = 0; i < 50; i++) if (m[i]) p = i;
    if (p == 49) begin
      m = {1'b0, m[49:2], m[1] | m[0]};
      e = e + 1;
    end else begin
      m = m << (48 - p);
      e = e - (48 - p);
    end
    if (e <= 0) begin
      sub = 1'b1;
      m = ((1 - e) > 49) ? {49'd0, |m} : shr_sticky(m, 1 - e);
    end
    rnd = m[24] && ((|m[23:0]) || m[25]);
    f = {1'b0, m[48:25]} + {24'd0, rnd};
    if (sub) begin
      // Rounding may carry a subnormal up into the smallest normal.
      r = {s, 7'd0, f[23], f[22:0]};
      unf = !f[23];
    end else begin
      if (f[24]) e = e + 1;
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0};
        ovf = 1'b1;
      end else begin
        r = {s, e[7:0], (f[24] ? 23'd0 : f[22:0])};
      end
    end
    return {ovf, unf, r};
  endfunction

  // Returns {invalid, overflow, underflow, result}.
  function automatic logic [34:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] big, sml;
    logic [49:0] mb, ms, sum;
    int          d;
    if (is_nan(x) || is_nan(y)) return {3'b000, QNAN};
    if (is_inf(x) && is_inf(y)) begin
      if (x[31] != y[31]) return {3'b100, QNAN};
      return {3'b000, x};
    end
    if (is_inf(x)) return {3'b000, x};
    if (is_inf(y)) return {3'b000, y};
    if (x[30:0] < y[30:0]) begin
      big = y;
      sml = x;
    end else begin
      big = x;
      sml = y;
    end
    d  = exp_of(big) - exp_of(sml);
    mb = {1'b0, sig_of(big), 25'd0};
    ms = {1'b0, sig_of(sml), 25'd0};
    ms = (d > 49) ? {49'd0, |ms} : shr_sticky(ms, d);
    sum = (big[31] == sml[31]) ? (mb + ms) : (mb - ms);
    // Exact zero is +0 unless both addends were negative.
    if (sum == 50'd0) return {3'b000, (x[31] & y[31]), 31'd0};
    return {1'b0, round_pack(big[31], exp_of(big), sum)};
  endfunction

  function automatic logic [34:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    logic [47:0] prod;
    s = x[31] ^ y[31];
    if (is_nan(x) || is_nan(y)) return {3'b000, QNAN};
    if ((is_inf(x) && is_zero(y)) || (is_zero(x) && is_inf(y))) return {3'b100, QNAN};
    if (is_inf(x) || is_inf(y)) return {3'b000, s, 8'hFF, 23'd0};
    prod = sig_of(x) * sig_of(y);
    return {1'b0, round_pack(s, exp_of(x) + exp_of(y) - 127, {prod, 2'b00})};
  endfunction

  // Ordered greater-than; false with any NaN, and +0/-0 are equal.
  function automatic logic fp_gt(input logic [31:0] x, input logic [31:0] y);
    logic r;
    if (is_nan(x) || is_nan(y) || (is_zero(x) && is_zero(y))) r = 1'b0;
    else if (x[31] != y[31]) r = !x[31];
    else if (!x[31]) r = x[30:0] > y[30:0];
    else r = x[30:0] < y[30:0];
    return r;
  endfunction

  function automatic logic fp_eq(input logic [31:0] x, input logic [31:0] y);
    return !is_nan(x) && !is_nan(y) && ((x == y) || (is_zero(x) && is_zero(y)));
  endfunction

  function automatic logic [31:0] fp_minmax(input logic [31:0] x, input logic [31:0] y,
                                            input logic want_max);
    if (is_nan(x) && is_nan(y)) return QNAN;
    if (is_nan(x)) return y;
    if (is_nan(y)) return x;
    if (is_zero(x) && is_zero(y))
      return want_max ? {x[31] & y[31], 31'd0} : {x[31] | y[31], 31'd0};
    if (want_max) return fp_gt(y, x) ? y : x;
    return fp_gt(y, x) ? x : y;
  endfunction

  logic [34:0]      alu_r;
  logic [31:0]      res_d;
  logic             gt_d;
  logic             stall;
  logic [LATENCY-1:0] v_q;
  logic [31:0]      res_q [LATENCY];
  logic             gt_q  [LATENCY];
  logic [TAG_W-1:0] tag_q [LATENCY];

  // Result of the op currently presented; captured into stage 0 on accept.
  always_comb begin
    alu_r = 35'd0;
    gt_d  = 1'b0;
    case (op)
      3'b000:  alu_r = fp_add(a, b);
      3'b001:  alu_r = fp_add(a, {~b[31], b[30:0]});
      3'b010:  alu_r = fp_mul(a, b);
      3'b011:  begin
        alu_r = {3'b000, b};
        gt_d  = fp_gt(a, b);
      end
      3'b100:  alu_r = {3'b000, fp_minmax(a, b, 1'b0)};
      3'b101:  alu_r = {3'b000, fp_minmax(a, b, 1'b1)};
      3'b110:  alu_r = {34'd0, fp_eq(a, b)};
      default: alu_r = 35'd0;
    endcase
  end

  assign res_d     = alu_r[31:0];
  assign out_valid = v_q[LATENCY-1];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign out       = res_q[LATENCY-1];
  assign gt        = gt_q[LATENCY-1];
  assign out_tag   = tag_q[LATENCY-1];

  // Stage shift register: reset clears everything, a stall freezes all stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        res_q[i] <= '0;
        gt_q[i]  <= 1'b0;
        tag_q[i] <= '0;
      end
    end else if (!stall) begin
      v_q[0]   <= in_valid;
      res_q[0] <= res_d;
      gt_q[0]  <= gt_d;
      tag_q[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        v_q[i]   <= v_q[i-1];
        res_q[i] <= res_q[i-1];
        gt_q[i]  <= gt_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

`ifdef FP_ALU_EXC_EN
  logic [2:0] exc_q [LATENCY];

  // Exception flags travel in lock-step with their data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) exc_q[i] <= 3'b000;
    end else if (!stall) begin
      exc_q[0] <= alu_r[34:32];
      for (int i = 1; i < LATENCY; i++) exc_q[i] <= exc_q[i-1];
    end
  end

  assign exc = exc_q[LATENCY-1];
`else
  logic unused_exc;
  assign unused_exc = ^alu_r[34:32];
`endif

endmodule

// File: tb/tb_fp_alu_pipe.sv
// Directed bench for fp_alu_pipe: a driver pushes hand-computed results into a
// scoreboard queue on accept; a monitor pops and compares on every output handshake.
module tb_fp_alu_pipe;
  localparam int LAT = 2;
  localparam int TW  = 5;
`ifdef FP_ALU_EXC_EN
  localparam logic [2:0] EXC_MASK = 3'b111;
`else
  localparam logic [2:0] EXC_MASK = 3'b000;
`endif
  localparam int W = 32 + 1 + TW + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   a;
  logic [31:0]   b;
  logic [2:0]    op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out;
  logic          gt;
  logic [TW-1:0] out_tag;
`ifdef FP_ALU_EXC_EN
  logic [2:0]    exc;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  int pop_cyc[$];
  logic [W-1:0] act_v;

  fp_alu_pipe #(.LATENCY(LAT), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .gt(gt), .out_tag(out_tag)
`ifdef FP_ALU_EXC_EN
    , .exc(exc)
`endif
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef FP_ALU_EXC_EN
  always_comb act_v = {out, gt, out_tag, exc};
`else
  always_comb act_v = {out, gt, out_tag, 3'b000};
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every output handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h expected no result", act_v);
      end else begin
        check("result", act_v, exp_q.pop_front());
      end
      pop_cyc.push_back(cyc);
    end
  end

  // Driver: present one op, wait (bounded) for acceptance, push its expectation.
  task automatic send(input logic [31:0] ta, input logic [31:0] tbv, input logic [2:0] top,
                      input logic [TW-1:0] tag, input logic [31:0] er, input logic eg,
                      input logic [2:0] ee, input bit keep);
    int waitc = 0;
    a = ta;
    b = tbv;
    op = top;
    in_tag = tag;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waitc < 50) begin
      waitc++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else if (keep) begin
      exp_q.push_back({er, eg, tag, ee & EXC_MASK});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts negedges after acceptance until out_valid shows up.
  task automatic measure_latency(input string name);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check(name, lat, LAT);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [2:0]  vop;
    logic [31:0] vres;
    logic        vgt;
    logic [2:0]  vexc;
  } vec_t;

  vec_t vecs[20] = '{
    '{32'h7FC00000, 32'h3F800000, 3'b100, 32'h3F800000, 1'b0, 3'b000},
    '{32'h7FC00000, 32'h3F800000, 3'b011, 32'h3F800000, 1'b0, 3'b000},
    '{32'h7F800000, 32'h7F800000, 3'b001, 32'h7FC00000, 1'b0, 3'b100},
    '{32'h7F7FFFFF, 32'h40000000, 3'b010, 32'h7F800000, 1'b0, 3'b010},
    '{32'h80000000, 32'h00000000, 3'b100, 32'h80000000, 1'b0, 3'b000},
    '{32'h80000000, 32'h00000000, 3'b101, 32'h00000000, 1'b0, 3'b000},
    '{32'h00000000, 32'h80000000, 3'b110, 32'h00000001, 1'b0, 3'b000},
    '{32'h3F800000, 32'h40000000, 3'b110, 32'h00000000, 1'b0, 3'b000},
    '{32'h3F800000, 32'h40000000, 3'b011, 32'h40000000, 1'b0, 3'b000},
    '{32'h3F800000, 32'h3F800000, 3'b001, 32'h00000000, 1'b0, 3'b000},
    '{32'h00800000, 32'h3F000000, 3'b010, 32'h00400000, 1'b0, 3'b001},
    '{32'h3F800000, 32'h33800000, 3'b000, 32'h3F800000, 1'b0, 3'b000},
    '{32'h3F800001, 32'h33800000, 3'b000, 32'h3F800002, 1'b0, 3'b000},
    '{32'h40000000, 32'hC0400000, 3'b000, 32'hBF800000, 1'b0, 3'b000},
    '{32'h12345678, 32'h9ABCDEF0, 3'b111, 32'h00000000, 1'b0, 3'b000},
    '{32'h7FC00000, 32'h7FC00000, 3'b101, 32'h7FC00000, 1'b0, 3'b000},
    '{32'h00000000, 32'h7F800000, 3'b010, 32'h7FC00000, 1'b0, 3'b100},
    '{32'hBF800000, 32'hC0000000, 3'b011, 32'hC0000000, 1'b1, 3'b000},
    '{32'h3F800000, 32'h7FC00000, 3'b101, 32'h3F800000, 1'b0, 3'b000},
    '{32'h7F7FFFFF, 32'h7F7FFFFF, 3'b000, 32'h7F800000, 1'b0, 3'b010}
  };

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    op = '0;
    in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_gt", gt, 0);
    check("rst_out_tag", out_tag, 0);
`ifdef FP_ALU_EXC_EN
    check("rst_exc", exc, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    // Single add with latency measurement.
    send(32'h3FC00000, 32'h40100000, 3'b000, 5'd5, 32'h40700000, 1'b0, 3'b000, 1'b1);
    measure_latency("latency_add");
    idle(3);

    // Back-to-back mul then compare.
    send(32'h40000000, 32'h40400000, 3'b010, 5'd1, 32'h40C00000, 1'b0, 3'b000, 1'b1);
    send(32'h40400000, 32'h40000000, 3'b011, 5'd2, 32'h40000000, 1'b1, 3'b000, 1'b1);
    idle(4);
    check("b2b_consecutive", pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2], 1);

    // Directed vector table, streamed at full rate.
    for (int i = 0; i < 20; i++)
      send(vecs[i].va, vecs[i].vb, vecs[i].vop, TW'(i), vecs[i].vres, vecs[i].vgt,
           vecs[i].vexc, 1'b1);
    idle(5);

    // Backpressure: 4 ops, consumer stalls for 3 cycles once out_valid rises.
    fork
      begin
        send(32'h3F800000, 32'h3F800000, 3'b000, 5'd10, 32'h40000000, 1'b0, 3'b000, 1'b1);
        send(32'h40000000, 32'h40400000, 3'b010, 5'd11, 32'h40C00000, 1'b0, 3'b000, 1'b1);
        send(32'h40400000, 32'h3F800000, 3'b001, 5'd12, 32'h40000000, 1'b0, 3'b000, 1'b1);
        send(32'h3F800000, 32'h40000000, 3'b100, 5'd13, 32'h3F800000, 1'b0, 3'b000, 1'b1);
      end
      begin
        int w = 0;
        do begin
          @(posedge clk);
          #1;
          w++;
        end while (!out_valid && w < 20);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          check("stall_hold", {out, out_tag}, {32'h40000000, 5'd10});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(8);
    check("bp_all_delivered", exp_q.size(), 0);

    // Reset mid-flight: two ops held in the pipe, then one reset edge.
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 3'b000, 5'd20, 32'h0, 1'b0, 3'b000, 1'b0);
    send(32'h40000000, 32'h40000000, 3'b010, 5'd21, 32'h0, 1'b0, 3'b000, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out", out, 0);
    check("midrst_out_tag", out_tag, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(5);
    send(32'h40400000, 32'h3F800000, 3'b001, 5'd22, 32'h40000000, 1'b0, 3'b000, 1'b1);
    measure_latency("latency_after_reset");

    begin
      int d = 0;
      while (exp_q.size() != 0 && d < 50) begin
        @(posedge clk);
        d++;
      end
    end
    idle(2);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
